// File: rtl/key_sw_conditioner.sv
// Synchronises, debounces and edge-detects active-low keys/switches; per-key long-press FSM (auto-repeat when KEY_AUTO_REPEAT_EN is defined).
// Latency: raw edge to level/pulse output is 2 + DEBOUNCE_CYC cycles; no backpressure, outputs are free-running.
module key_sw_conditioner #(
  parameter int KEY_NUM      = 3,
  parameter int SW_NUM       = 3,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic               fpga_clk_50,
  input  logic               fpga_rst_n,
  input  logic [KEY_NUM-1:0] usr_key_i,
  input  logic [SW_NUM-1:0]  usr_sw_i,
  output logic [KEY_NUM-1:0] key_down_o,
  output logic [KEY_NUM-1:0] key_press_o,
  output logic [KEY_NUM-1:0] key_release_o,
  output logic [KEY_NUM-1:0] key_long_o,
  output logic [SW_NUM-1:0]  sw_on_o,
  output logic [SW_NUM-1:0]  sw_change_o,
  output logic               any_event_o
);

  localparam int CH = KEY_NUM + SW_NUM;
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int LW = $clog2(LONG_CYC);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYC - 1);
  localparam logic [LW-1:0] HOLD_PRE  = LW'(LONG_CYC - 2);

  typedef enum logic [1:0] {K_IDLE = 2'd0, K_PRESSED = 2'd1, K_LONG = 2'd2} key_state_e;

  logic [CH-1:0]      raw;
  logic [CH-1:0]      sync1_q, sync2_q;
  logic [CH-1:0]      stable_q, stable_d;
  logic [CH-1:0]      rise, fall;
  logic [DW-1:0]      db_cnt_q [CH];
  logic [DW-1:0]      db_cnt_d [CH];
  key_state_e         kst_q [KEY_NUM];
  key_state_e         kst_d [KEY_NUM];
  logic [LW-1:0]      hold_q [KEY_NUM];
  logic [LW-1:0]      hold_d [KEY_NUM];
  logic [KEY_NUM-1:0] press_q, press_d, release_q, release_d, long_q, long_d, rep_pulse;
  logic [SW_NUM-1:0]  sw_chg_q, sw_chg_d;
  logic               any_q, any_d;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
  logic [RW-1:0] rep_q [KEY_NUM];
  logic [RW-1:0] rep_d [KEY_NUM];
`endif

  assign raw = {usr_sw_i, usr_key_i};

  always_comb begin
    stable_d = stable_q;
    for (int c = 0; c < CH; c++) begin
      db_cnt_d[c] = '0;
      if (sync2_q[c] != stable_q[c]) begin
        if (db_cnt_q[c] == DB_LAST) stable_d[c] = sync2_q[c];
        else                        db_cnt_d[c] = db_cnt_q[c] + DW'(1);
      end
    end
  end

  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

  always_comb begin
    for (int k = 0; k < KEY_NUM; k++) begin
      kst_d[k]     = kst_q[k];
      hold_d[k]    = hold_q[k];
      long_d[k]    = 1'b0;
      rep_pulse[k] = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rep_d[k]     = rep_q[k];
`endif
      case (kst_q[k])
        K_IDLE: begin
          if (rise[k]) begin
            kst_d[k]  = K_PRESSED;
            hold_d[k] = '0;
          end
        end
        K_PRESSED: begin
          // a release landing on the terminal count wins, so no long pulse
          if (fall[k]) begin
            kst_d[k]  = K_IDLE;
            hold_d[k] = '0;
          end else if (hold_q[k] == HOLD_PRE) begin
            kst_d[k]  = K_LONG;
            hold_d[k] = HOLD_LAST;
            long_d[k] = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            rep_d[k]  = '0;
`endif
          end else begin
            hold_d[k] = hold_q[k] + LW'(1);
          end
        end
        K_LONG: begin
          if (fall[k]) begin
            kst_d[k]  = K_IDLE;
            hold_d[k] = '0;
`ifdef KEY_AUTO_REPEAT_EN
            rep_d[k]  = '0;
          end else if (rep_q[k] == REP_LAST) begin
            rep_d[k]     = '0;
            rep_pulse[k] = 1'b1;
          end else begin
            rep_d[k] = rep_q[k] + RW'(1);
`endif
          end
        end
        default: begin
          kst_d[k]  = K_IDLE;
          hold_d[k] = '0;
        end
      endcase
    end
    press_d   = rise[KEY_NUM-1:0] | rep_pulse;
    release_d = fall[KEY_NUM-1:0];
    sw_chg_d  = rise[CH-1:KEY_NUM] | fall[CH-1:KEY_NUM];
    any_d     = |{press_d, release_d, long_d, sw_chg_d};
  end

  always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '0;  // second stage is already active-high: 0 means released/off
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      sw_chg_q  <= '0;
      any_q     <= 1'b0;
      for (int c = 0; c < CH; c++) db_cnt_q[c] <= '0;
      for (int k = 0; k < KEY_NUM; k++) begin
        kst_q[k]  <= K_IDLE;
        hold_q[k] <= '0;
`ifdef KEY_AUTO_REPEAT_EN
        rep_q[k]  <= '0;
`endif
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= ~sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      sw_chg_q  <= sw_chg_d;
      any_q     <= any_d;
      for (int c = 0; c < CH; c++) db_cnt_q[c] <= db_cnt_d[c];
      for (int k = 0; k < KEY_NUM; k++) begin
        kst_q[k]  <= kst_d[k];
        hold_q[k] <= hold_d[k];
`ifdef KEY_AUTO_REPEAT_EN
        rep_q[k]  <= rep_d[k];
`endif
      end
    end
  end

  assign key_down_o    = stable_q[KEY_NUM-1:0];
  assign sw_on_o       = stable_q[CH-1:KEY_NUM];
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_long_o    = long_q;
  assign sw_change_o   = sw_chg_q;
  assign any_event_o   = any_q;

endmodule

// File: tb/tb_key_sw_conditioner.sv
// Directed bench for key_sw_conditioner with DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8.
module tb_key_sw_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] usr_key, usr_sw;
  logic [2:0] key_down, key_press, key_release, key_long, sw_on, sw_change;
  logic       any_event;
  logic [18:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_sw_conditioner #(
    .KEY_NUM(3), .SW_NUM(3), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(8)
  ) dut (
    .fpga_clk_50  (clk),
    .fpga_rst_n   (rst_n),
    .usr_key_i    (usr_key),
    .usr_sw_i     (usr_sw),
    .key_down_o   (key_down),
    .key_press_o  (key_press),
    .key_release_o(key_release),
    .key_long_o   (key_long),
    .sw_on_o      (sw_on),
    .sw_change_o  (sw_change),
    .any_event_o  (any_event)
  );

  assign obs = {key_down, key_press, key_release, key_long, sw_on, sw_change, any_event};

  typedef struct {
    logic [2:0]  key;
    logic [2:0]  sw;
    int          n;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic [2:0] key, input logic [2:0] sw, input int n,
                              input logic [2:0] dn, input logic [2:0] pr, input logic [2:0] rl,
                              input logic [2:0] lg, input logic [2:0] so, input logic [2:0] sc,
                              input logic an);
    vec_t v;
    v.key = key;
    v.sw  = sw;
    v.n   = n;
    v.exp = {dn, pr, rl, lg, so, sc, an};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    int press_t[$];
    int long_t[$];
    int rel_t[$];
    int first_press, first_long;

    //        key     sw      n   down    press   rel     long    sw_on   sw_chg  any
    vecs[0]  = mk(3'b111, 3'b111, 50, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[1]  = mk(3'b110, 3'b111, 5,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[2]  = mk(3'b110, 3'b111, 1,  3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
    vecs[3]  = mk(3'b110, 3'b111, 4,  3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[4]  = mk(3'b111, 3'b111, 5,  3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[5]  = mk(3'b111, 3'b111, 1,  3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1);
    vecs[6]  = mk(3'b111, 3'b111, 3,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[7]  = mk(3'b101, 3'b111, 3,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[8]  = mk(3'b111, 3'b111, 6,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[9]  = mk(3'b101, 3'b111, 4,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[10] = mk(3'b111, 3'b111, 1,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[11] = mk(3'b111, 3'b111, 1,  3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
    vecs[12] = mk(3'b111, 3'b111, 3,  3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[13] = mk(3'b111, 3'b111, 1,  3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1);
    vecs[14] = mk(3'b111, 3'b111, 3,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[15] = mk(3'b110, 3'b010, 5,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    vecs[16] = mk(3'b110, 3'b010, 1,  3'b001, 3'b001, 3'b000, 3'b000, 3'b101, 3'b101, 1'b1);
    vecs[17] = mk(3'b110, 3'b010, 3,  3'b001, 3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 1'b0);
    vecs[18] = mk(3'b111, 3'b111, 5,  3'b001, 3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 1'b0);
    vecs[19] = mk(3'b111, 3'b111, 1,  3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b101, 1'b1);
    vecs[20] = mk(3'b111, 3'b111, 3,  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    rst_n   = 1'b0;
    usr_key = 3'b111;
    usr_sw  = 3'b111;
    tick();
    tick();
    chk("reset_state", 32'(obs), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      usr_key = vecs[i].key;
      usr_sw  = vecs[i].sw;
      for (int c = 0; c < vecs[i].n; c++) begin
        tick();
        chk($sformatf("vec%0d_cyc%0d", i, c), 32'(obs), 32'(vecs[i].exp));
      end
    end

    // key 2 held for 40 cycles: press, one long pulse, optional repeats, release
    usr_key = 3'b011;
    for (int t = 1; t <= 60; t++) begin
      if (t == 41) usr_key = 3'b111;
      tick();
      if (key_press[2])   press_t.push_back(t);
      if (key_long[2])    long_t.push_back(t);
      if (key_release[2]) rel_t.push_back(t);
      if (t == 25) chk("long_any_event", 32'(any_event), 32'd1);
    end
    chk("long_press_tick", 32'(press_t.size() > 0 ? press_t[0] : -1), 32'd6);
    chk("long_count", 32'(long_t.size()), 32'd1);
    chk("long_tick", 32'(long_t.size() > 0 ? long_t[0] : -1), 32'd25);
    chk("long_rel_count", 32'(rel_t.size()), 32'd1);
    chk("long_rel_tick", 32'(rel_t.size() > 0 ? rel_t[0] : -1), 32'd46);
`ifdef KEY_AUTO_REPEAT_EN
    chk("repeat_count", 32'(press_t.size()), 32'd3);
    chk("repeat1_tick", 32'(press_t.size() > 1 ? press_t[1] : -1), 32'd33);
    chk("repeat2_tick", 32'(press_t.size() > 2 ? press_t[2] : -1), 32'd41);
`else
    chk("press_count", 32'(press_t.size()), 32'd1);
`endif
    for (int t = 0; t < 5; t++) tick();
    chk("idle_after_long", 32'(obs), 32'h0);

    // reset while key 0 held with its hold counter at 10
    usr_key = 3'b110;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 6) chk("pre_rst_press", 32'(key_press[0]), 32'd1);
    end
    chk("pre_rst_down", 32'(key_down[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_clear", 32'(obs), 32'h0);
    tick();
    tick();
    chk("in_rst_quiet", 32'(obs), 32'h0);
    rst_n = 1'b1;
    first_press = -1;
    first_long  = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (key_press[0] && first_press < 0) first_press = t;
      if (key_long[0] && first_long < 0)   first_long  = t;
    end
    chk("post_rst_press_tick", 32'(first_press), 32'd6);
    chk("post_rst_long_tick", 32'(first_long), 32'd25);
    usr_key = 3'b111;
    for (int t = 0; t < 10; t++) tick();
    chk("final_idle", 32'(obs), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
